// File: rtl/rnn_pkg.sv
// rnn_pkg: bank select encoding, bank geometry and host-port FSM states.
package rnn_pkg;
  localparam logic [2:0] SEL_WIH = 3'b000;
  localparam logic [2:0] SEL_BIH = 3'b001;
  localparam logic [2:0] SEL_WHH = 3'b010;
  localparam logic [2:0] SEL_BHH = 3'b011;
  localparam logic [2:0] SEL_SEQ = 3'b100;
  localparam logic [2:0] SEL_OUT = 3'b101;
  localparam int N_H = 64;
  localparam int N_X = 32;
  localparam int WIH_DEPTH = N_H * N_X;
  localparam int WHH_DEPTH = N_H * N_H;
  localparam int WIH_AW = $clog2(WIH_DEPTH);
  localparam int WHH_AW = $clog2(WHH_DEPTH);
  localparam int B_AW = $clog2(N_H);
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/rnn_xfifo.sv
// rnn_xfifo: synchronous FIFO; head is zero while empty, popping empty flags underflow.
module rnn_xfifo #(
  parameter int W = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    do_pop = pop && !empty;
    // a pop frees the slot, so a push while full still lands when paired with one
    do_push = push && (!full || do_pop);
    underflow = pop && empty;
    wp_d = wp_q + (AW+1)'(do_push);
    rp_d = rp_q + (AW+1)'(do_pop);
    dout = empty ? '0 : mem[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp_q[AW-1:0]] <= din;
endmodule

// File: rtl/rnn_host_port.sv
// rnn_host_port: host-side bank responder, input FIFO and run sequencer for the RNN accelerator.
module rnn_host_port
  import rnn_pkg::*;
#(
  parameter int T_MAX = 16,
  parameter int XFIFO_DEPTH = 16,
  parameter int DW = 20,
  parameter int WD_W = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_start,
  input  logic          ld_en,
  input  logic [2:0]    ld_sel,
  input  logic [16:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          x_push,
  input  logic [31:0]   x_in,
  output logic          x_full,
  input  logic [16:0]   rb_addr,
  output logic [DW-1:0] rb_data,
  output logic          done,
  output logic [3:0]    err,
  output logic          ready,
  input  logic          busy,
  input  logic          i_en,
  output logic [31:0]   idata,
  input  logic          mce,
  input  logic [2:0]    msel,
  input  logic [16:0]   maddr,
  input  logic [DW-1:0] mdata_w,
  output logic [DW-1:0] mdata_r
);
  localparam int OUT_DEPTH = T_MAX * N_H;
  localparam int OB = $clog2(OUT_DEPTH);
  localparam logic [16:0] OUT_LIM = 17'(OUT_DEPTH);
  logic [DW-1:0] w_ih [WIH_DEPTH];
  logic [DW-1:0] w_hh [WHH_DEPTH];
  logic [DW-1:0] b_ih [N_H];
  logic [DW-1:0] b_hh [N_H];
  logic [DW-1:0] out_mem [OUT_DEPTH];
  logic [DW-1:0] seq_len;
  state_e state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [3:0] err_q, err_d;
  logic [DW-1:0] mdata_r_q, mdata_r_d, rb_data_q, rb_data_d, out_wd;
  logic [OB-1:0] out_wa;
  logic x_empty, x_uf, acc_wr, ovf, ld_ok, out_we, start_ok, wd_fire;

  rnn_xfifo #(.W(32), .DEPTH(XFIFO_DEPTH)) u_xfifo (
    .clk(clk), .reset(reset), .push(x_push), .pop(i_en), .din(x_in),
    .dout(idata), .full(x_full), .empty(x_empty), .underflow(x_uf)
  );

  always_comb begin
    acc_wr = mce && msel == SEL_OUT && maddr < OUT_LIM;
    ovf = mce && msel == SEL_OUT && maddr >= OUT_LIM;
    ld_ok = ld_en && state_q == ST_IDLE;
    out_we = acc_wr || (ld_ok && ld_sel == SEL_OUT && ld_addr < OUT_LIM);
    out_wa = acc_wr ? maddr[OB-1:0] : ld_addr[OB-1:0];
    out_wd = acc_wr ? mdata_w : ld_data;
    mdata_r_d = msel == SEL_WIH ? w_ih[maddr[WIH_AW-1:0]] :
                msel == SEL_BIH ? b_ih[maddr[B_AW-1:0]] :
                msel == SEL_WHH ? w_hh[maddr[WHH_AW-1:0]] :
                msel == SEL_BHH ? b_hh[maddr[B_AW-1:0]] :
                msel == SEL_SEQ ? seq_len : '0;
    rb_data_d = rb_addr < OUT_LIM ? out_mem[rb_addr[OB-1:0]] : '0;
  end

  always_comb begin
    state_d = state_q;
    ready = 1'b0;
    done = 1'b0;
    start_ok = state_q == ST_IDLE && host_start && !x_empty;
    wd_d = state_q == ST_IDLE ? '0 : wd_q + 1'b1;
    wd_fire = (state_q == ST_ARM || state_q == ST_RUN) && &wd_q;
    case (state_q)
      ST_IDLE: state_d = start_ok ? ST_ARM : ST_IDLE;
      ST_ARM: begin
        ready = 1'b1;
        state_d = busy ? ST_RUN : ST_ARM;
      end
      ST_RUN: state_d = busy ? ST_RUN : ST_DONE;
      default: begin
        done = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    if (wd_fire) state_d = ST_DONE;
    err_d = (start_ok ? 4'b0 : err_q) | {wd_fire, ld_en && state_q != ST_IDLE, x_uf, ovf};
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      wd_q <= '0;
      err_q <= '0;
      mdata_r_q <= '0;
      rb_data_q <= '0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      err_q <= err_d;
      mdata_r_q <= mdata_r_d;
      rb_data_q <= rb_data_d;
    end

  // bank contents survive reset; only the loader (IDLE) and accelerator writes change them
  always_ff @(posedge clk) begin
    if (out_we) out_mem[out_wa] <= out_wd;
    if (ld_ok && ld_sel == SEL_WIH) w_ih[ld_addr[WIH_AW-1:0]] <= ld_data;
    if (ld_ok && ld_sel == SEL_WHH) w_hh[ld_addr[WHH_AW-1:0]] <= ld_data;
    if (ld_ok && ld_sel == SEL_BIH) b_ih[ld_addr[B_AW-1:0]] <= ld_data;
    if (ld_ok && ld_sel == SEL_BHH) b_hh[ld_addr[B_AW-1:0]] <= ld_data;
    if (ld_ok && ld_sel == SEL_SEQ) seq_len <= ld_data;
  end

  assign err = err_q;
  assign mdata_r = mdata_r_q;
  assign rb_data = rb_data_q;
endmodule

// File: tb/tb_rnn_host_port.sv
// tb_rnn_host_port: directed + randomized checks of rnn_host_port against a queue/array reference model.
module tb_rnn_host_port;
  import rnn_pkg::*;
  localparam int T_MAX = 16, XD = 16, WD_W = 8;
  logic clk = 1'b0, reset = 1'b1, host_start = 1'b0, ld_en = 1'b0;
  logic [2:0] ld_sel = '0, msel = 3'b110;
  logic [16:0] ld_addr = '0, rb_addr = '0, maddr = '0;
  logic [19:0] ld_data = '0, mdata_w = '0, rb_data, mdata_r;
  logic x_push = 1'b0, busy = 1'b0, i_en = 1'b0, mce = 1'b0;
  logic [31:0] x_in = '0, idata;
  logic x_full, done, ready;
  logic [3:0] err;
  int n_chk = 0, n_pass = 0;
  logic [31:0] q[$];
  logic [19:0] m_wih[int], m_whh[int], m_bih[int], m_bhh[int], m_out[int], m_seq;
  logic [3:0] m_err = '0;
  logic [2:0] ls[$];
  logic [16:0] la[$];

  always #5 clk = ~clk;

  rnn_host_port #(.T_MAX(T_MAX), .XFIFO_DEPTH(XD), .DW(20), .WD_W(WD_W)) dut (
    .clk(clk), .reset(reset), .host_start(host_start), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .x_push(x_push), .x_in(x_in), .x_full(x_full),
    .rb_addr(rb_addr), .rb_data(rb_data), .done(done), .err(err), .ready(ready),
    .busy(busy), .i_en(i_en), .idata(idata), .mce(mce), .msel(msel), .maddr(maddr),
    .mdata_w(mdata_w), .mdata_r(mdata_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] s, input logic [16:0] a, input logic [19:0] d);
    ld_en = 1'b1; ld_sel = s; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    case (s)
      SEL_WIH: m_wih[int'(a[10:0])] = d;
      SEL_BIH: m_bih[int'(a[5:0])] = d;
      SEL_WHH: m_whh[int'(a[11:0])] = d;
      SEL_BHH: m_bhh[int'(a[5:0])] = d;
      SEL_SEQ: m_seq = d;
      default: if (int'(a) < T_MAX * 64) m_out[int'(a)] = d;
    endcase
  endtask

  function automatic logic [19:0] mexp(input logic [2:0] s, input logic [16:0] a);
    case (s)
      SEL_WIH: return m_wih[int'(a[10:0])];
      SEL_BIH: return m_bih[int'(a[5:0])];
      SEL_WHH: return m_whh[int'(a[11:0])];
      SEL_BHH: return m_bhh[int'(a[5:0])];
      SEL_SEQ: return m_seq;
      default: return 20'h0;
    endcase
  endfunction

  function automatic logic [16:0] hi_mask(input logic [2:0] s);
    return s == SEL_WIH ? 17'h1F800 : s == SEL_WHH ? 17'h1F000 : 17'h1FFC0;
  endfunction

  task automatic push_v(input logic [31:0] v);
    x_push = 1'b1; x_in = v;
    tick();
    x_push = 1'b0;
    if (q.size() < XD) q.push_back(v);
  endtask

  initial begin
    logic [16:0] a;
    logic [19:0] v0, v1;
    int cnt;
    logic p, o;
    tick();
    tick();
    chk("rst_ready", ready, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_mdata_r", mdata_r, 0); chk("rst_rb_data", rb_data, 0);
    chk("rst_x_full", x_full, 0); chk("rst_idata", idata, 0);
    reset = 1'b0;
    tick();
    // random bank loads, read back with the ignored upper address bits scrambled
    for (int i = 0; i < 10; i++) begin
      ls.push_back(3'($urandom_range(0, 3)));
      la.push_back(17'($urandom));
      ld(ls[i], la[i], 20'($urandom));
    end
    for (int i = 0; i < 10; i++) begin
      msel = ls[i];
      maddr = la[i] ^ (17'($urandom) & hi_mask(ls[i]));
      tick();
      chk("bank_read", mdata_r, mexp(ls[i], la[i]));
    end
    msel = SEL_OUT; tick(); chk("rd_out_zero", mdata_r, 0);
    msel = 3'b111; tick(); chk("rd_111_zero", mdata_r, 0);
    // W_hh[{5,7}] one-cycle latency
    ld(SEL_WHH, 17'h147, 20'hFFFFF);
    msel = 3'b110; tick();
    msel = SEL_WHH; maddr = 17'h147;
    chk("lat_before_edge", mdata_r, 0);
    tick();
    chk("whh_147", mdata_r, 20'hFFFFF);
    msel = 3'b110;
    tick();
    chk("rd_110_zero", mdata_r, 0);
    // nominal run
    ld(SEL_SEQ, 17'($urandom), 20'd2);
    v0 = 20'($urandom);
    ld(SEL_OUT, 17'd127, v0);
    push_v($urandom); push_v($urandom);
    msel = SEL_SEQ; maddr = 17'($urandom);
    tick();
    chk("seq_len_idle", mdata_r, 2);
    host_start = 1'b1; tick(); host_start = 1'b0;
    chk("ready_arm", ready, 1);
    tick();
    chk("ready_hold", ready, 1);
    busy = 1'b1; tick();
    chk("ready_drop", ready, 0);
    rb_addr = 17'd127;
    for (int c = 0; c < 100; c++) begin
      i_en = (c == 10 || c == 20);
      if (i_en) chk("idata_run", idata, q[0]);
      if (c == 30) begin
        mce = 1'b1; msel = SEL_OUT; maddr = 17'd127; mdata_w = 20'h0ABCD;
      end
      tick();
      if (i_en) void'(q.pop_front());
      if (c == 30) chk("rb_same_edge_old", rb_data, v0);
      if (c == 31) chk("rb_after_write", rb_data, 20'h0ABCD);
      i_en = 1'b0; mce = 1'b0; msel = SEL_SEQ;
    end
    m_out[127] = 20'h0ABCD;
    chk("done_during_run", done, 0);
    busy = 1'b0; tick();
    chk("done_pulse", done, 1);
    tick();
    chk("done_once", done, 0); chk("fifo_empty_run", idata, 0);
    chk("err_run", err, 0); chk("ready_idle", ready, 0);
    // output overflow
    v0 = 20'($urandom);
    ld(SEL_OUT, 17'd0, v0);
    mce = 1'b1; msel = SEL_OUT; maddr = 17'(T_MAX * 64); mdata_w = ~v0;
    rb_addr = 17'd0;
    tick();
    mce = 1'b0; m_err[0] = 1'b1;
    chk("ovf_err", err, m_err);
    tick();
    chk("ovf_no_write", rb_data, v0);
    // underflow and full
    i_en = 1'b1; tick(); i_en = 1'b0;
    m_err[1] = 1'b1;
    chk("uf_idata", idata, 0); chk("uf_err", err, m_err); chk("uf_not_full", x_full, 0);
    for (int i = 0; i < 15; i++) push_v($urandom);
    chk("fill15_not_full", x_full, 0);
    push_v($urandom);
    chk("fill16_full", x_full, 1);
    push_v($urandom);
    chk("push17_full", x_full, 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_head", idata, q[0]);
      i_en = 1'b1; tick(); i_en = 1'b0;
      void'(q.pop_front());
    end
    chk("drain_empty", idata, 0); chk("drain_not_full", x_full, 0); chk("drain_err", err, m_err);
    // randomized FIFO traffic
    for (int c = 0; c < 200; c++) begin
      p = $urandom_range(0, 9) < 6;
      o = $urandom_range(0, 9) < 4;
      if (q.size() == XD && o) p = 1'b0;
      x_push = p; x_in = $urandom; i_en = o;
      chk("rnd_head", idata, q.size() ? q[0] : 32'h0);
      tick();
      if (o) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err[1] = 1'b1;
      end
      if (p && q.size() < XD) q.push_back(x_in);
      x_push = 1'b0; i_en = 1'b0;
      chk("rnd_full", x_full, q.size() == XD);
      chk("rnd_err", err, m_err);
    end
    // load attempted during RUN
    a = 17'($urandom); v0 = 20'($urandom); v1 = ~v0;
    ld(SEL_WIH, a, v0);
    if (q.size() == 0) push_v($urandom);
    host_start = 1'b1; busy = 1'b1; tick(); host_start = 1'b0;
    m_err = '0;
    tick();
    chk("lir_run", ready, 0);
    ld_en = 1'b1; ld_sel = SEL_WIH; ld_addr = a; ld_data = v1;
    tick();
    ld_en = 1'b0; m_err[2] = 1'b1;
    chk("lir_err", err, m_err);
    busy = 1'b0; tick();
    chk("lir_done", done, 1);
    msel = SEL_WIH; maddr = a;
    tick();
    chk("lir_unchanged", mdata_r, v0);
    // watchdog
    if (q.size() == 0) push_v($urandom);
    host_start = 1'b1; busy = 1'b1; tick(); host_start = 1'b0;
    m_err = '0;
    cnt = 0;
    while (!done && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("wd_done", done, 1);
    chk("wd_cycles", cnt >= (1 << WD_W) - 2 && cnt <= (1 << WD_W) + 2, 1);
    m_err[3] = 1'b1;
    chk("wd_err", err, m_err);
    tick();
    chk("wd_done_once", done, 0); chk("wd_idle", ready, 0);
    busy = 1'b0;
    // reset mid-ARM
    if (q.size() == 0) push_v($urandom);
    host_start = 1'b1; tick(); host_start = 1'b0;
    chk("rst_run_arm", ready, 1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ready", ready, 0); chk("async_rst_idata", idata, 0);
    chk("async_rst_err", err, 0); chk("async_rst_full", x_full, 0);
    tick();
    reset = 1'b0;
    q.delete(); m_err = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", done, 0);
      chk("rst_stay_idle", ready, 0);
    end
    host_start = 1'b1; tick(); host_start = 1'b0;
    chk("start_ignored_empty", ready, 0);
    msel = SEL_WHH; maddr = 17'h147;
    tick();
    chk("bank_kept_reset", mdata_r, 20'hFFFFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
